// File: rtl/rotate_seq_pkg.sv
// Shared types and defaults for the rotate sequencer: FSM state encoding,
// default strobe rates and the rate-select to divider-reload mapping.
package rotate_seq_pkg;

  // Default configuration (50 MHz system clock assumed for RATE3).
  localparam int unsigned DataWDef = 8;
  localparam int unsigned DivWDef  = 26;
  localparam int unsigned Rate0Def = 2;
  localparam int unsigned Rate1Def = 4;
  localparam int unsigned Rate2Def = 16;
  localparam int unsigned Rate3Def = 50000000;

  // Width of the step counter and of steps_left.
  localparam int unsigned StepsW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StShift,
    StDone
  } seq_state_e;

  // Map a rate select to the value the divider is reloaded with. The divider
  // counts reload..0 in WAIT and the strobe cycle itself adds one more, so a
  // reload of RATE-2 spaces strobes exactly RATE cycles apart.
  function automatic logic [31:0] rate_reload(input logic [1:0] sel,
                                              input int unsigned r0,
                                              input int unsigned r1,
                                              input int unsigned r2,
                                              input int unsigned r3);
    int unsigned rate;
    rate = r0;
    unique case (sel)
      2'd0: rate = r0;
      2'd1: rate = r1;
      2'd2: rate = r2;
      2'd3: rate = r3;
    endcase
    return 32'(rate - 32'd2);
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Loadable down-counter that paces the sequencer's shift strobes.
// Load has priority over count; the counter parks at zero.
module rate_divider #(
  parameter int unsigned DIV_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [DIV_W-1:0] r_count;

  // Count register: reload, count down while enabled, hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - DIV_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/rotate_sequencer.sv
// Command sequencer in front of the 8-bit rotating register. Accepts one
// load/rotate command per handshake and issues a parallel load followed by
// a paced series of shift strobes, then pulses done.
module rotate_sequencer
  import rotate_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned DIV_W  = DivWDef,
  parameter int unsigned RATE0  = Rate0Def,
  parameter int unsigned RATE1  = Rate1Def,
  parameter int unsigned RATE2  = Rate2Def,
  parameter int unsigned RATE3  = Rate3Def
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [DATA_W-1:0] i_cmd_data,
  input  logic              i_cmd_dir,
  input  logic              i_cmd_arith,
  input  logic [StepsW-1:0] i_cmd_steps,
  input  logic [1:0]        i_rate_sel,
  input  logic              i_abort,
  output logic [DATA_W-1:0] o_reg_data,
  output logic              o_reg_par_load,
  output logic              o_reg_rot_left,
  output logic              o_reg_asr,
  output logic              o_reg_shift_en,
  output logic              o_busy,
  output logic [StepsW-1:0] o_steps_left,
  output logic              o_done
);

  seq_state_e r_state;
  seq_state_e w_state_next;

  // Command fields latched at the handshake and held until the next one.
  logic [DATA_W-1:0] r_data;
  logic              r_dir;
  logic              r_arith;
  logic [StepsW-1:0] r_steps;
  logic [DIV_W-1:0]  r_reload;

  logic w_accept;
  logic w_div_load;
  logic w_div_en;
  logic w_div_zero;

  assign w_accept = (r_state == StIdle) && i_cmd_valid;

  // The divider is (re)armed on every strobe cycle and counts only in WAIT.
  assign w_div_load = (r_state == StLoad) || (r_state == StShift);
  assign w_div_en   = (r_state == StWait);

  rate_divider #(
    .DIV_W (DIV_W)
  ) u_rate_divider (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_div_load),
    .i_load_val (r_reload),
    .i_en       (w_div_en),
    .o_zero     (w_div_zero)
  );

  // Flag rate settings that would underflow the divider reload.
  always_ff @(posedge clk) begin
    assert (RATE0 >= 2 && RATE1 >= 2 && RATE2 >= 2 && RATE3 >= 2)
      else $error("rotate_sequencer: every RATE parameter must be >= 2");
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Command latches and step counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= '0;
      r_dir    <= 1'b0;
      r_arith  <= 1'b0;
      r_steps  <= '0;
      r_reload <= '0;
    end else if (w_accept) begin
      r_data   <= i_cmd_data;
      r_dir    <= i_cmd_dir;
      // Arithmetic shift only makes sense when shifting right.
      r_arith  <= i_cmd_arith & ~i_cmd_dir;
      r_steps  <= i_cmd_steps;
      r_reload <= DIV_W'(rate_reload(i_rate_sel, RATE0, RATE1, RATE2, RATE3));
    end else if ((r_state == StShift) && (r_steps != '0)) begin
      r_steps  <= r_steps - StepsW'(1);
    end
  end

  // Next-state logic; abort cancels only while strobes are still pending.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_cmd_valid) begin
          w_state_next = StLoad;
        end
      end
      StLoad: begin
        if (i_abort) begin
          w_state_next = StIdle;
        end else if (r_steps == '0) begin
          w_state_next = StDone;
        end else begin
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (i_abort) begin
          w_state_next = StIdle;
        end else if (w_div_zero) begin
          w_state_next = StShift;
        end
      end
      StShift: begin
        if (i_abort) begin
          w_state_next = StIdle;
        end else if (r_steps == StepsW'(1)) begin
          w_state_next = StDone;
        end else begin
          w_state_next = StWait;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Moore outputs: latched fields are visible only while busy.
  always_comb begin
    o_cmd_ready    = 1'b0;
    o_busy         = 1'b0;
    o_reg_data     = '0;
    o_reg_rot_left = 1'b0;
    o_reg_asr      = 1'b0;
    o_steps_left   = '0;
    o_reg_par_load = 1'b0;
    o_reg_shift_en = 1'b0;
    o_done         = 1'b0;
    if (r_state == StIdle) begin
      o_cmd_ready = 1'b1;
    end else begin
      o_busy         = 1'b1;
      o_reg_data     = r_data;
      o_reg_rot_left = r_dir;
      o_reg_asr      = r_arith;
      o_steps_left   = r_steps;
    end
    unique case (r_state)
      StLoad: begin
        o_reg_par_load = 1'b1;
        o_reg_shift_en = 1'b1;
      end
      StShift: begin
        o_reg_shift_en = 1'b1;
      end
      StDone: begin
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/rotate_sequencer.md
Name: rotate_sequencer

Overview:
- Control stage directly upstream of the 8-bit rotating register.
- Accepts one command per valid/ready handshake. A command is a load value, a direction, an arithmetic flag and a step count.
- Drives the register's parallel-load, rotate-direction, arithmetic-shift and shift-enable strobes at a selectable rate, so a pattern can rotate visibly on LEDs without manual KEY clocking.
- Reports busy, steps remaining and a one-cycle done pulse.

Parameters:
- DATA_W, 8: width of load value and of the downstream register.
- DIV_W, 26: width of the rate divider counter.
- RATE0, 2: cycles between strobes for rate_sel=0 (must be >=2).
- RATE1, 4: cycles between strobes for rate_sel=1.
- RATE2, 16: cycles between strobes for rate_sel=2.
- RATE3, 50000000: cycles between strobes for rate_sel=3 (1 Hz at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_data  in  DATA_W  value to parallel-load
- cmd_dir  in  1  0 = rotate right, 1 = rotate left
- cmd_arith  in  1  1 = arithmetic shift right (MSB holds); ignored when cmd_dir=1
- cmd_steps  in  4  number of shift operations after load, 0..15
- rate_sel  in  2  selects RATE0..RATE3, sampled at handshake
- abort  in  1  cancel the current command
- reg_data  out  DATA_W  parallel-load value to the register
- reg_par_load  out  1  load strobe
- reg_rot_left  out  1  direction for the current shift
- reg_asr  out  1  arithmetic-shift-right select
- reg_shift_en  out  1  register update enable, one cycle per operation
- busy  out  1  command in progress
- steps_left  out  4  shifts still to issue
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset: state IDLE. All outputs are 0 except cmd_ready, which is 1. Reset mid-command drops the command; no done pulse and no further strobes.
- FSM states: IDLE, LOAD, WAIT, SHIFT, DONE. busy=1 in every state except IDLE. cmd_ready=1 only in IDLE.
- IDLE:
  - On cmd_valid & cmd_ready, latch cmd_data, cmd_dir, cmd_arith & ~cmd_dir, cmd_steps and the selected RATE; go to LOAD.
  - cmd_valid while busy has no effect; the command is held by the source.
- LOAD (1 cycle):
  - reg_par_load=1, reg_shift_en=1, reg_data=latched value.
  - If steps=0, go to DONE.
  - Otherwise load the divider with RATE-2 and go to WAIT.
- WAIT:
  - Decrement the divider each cycle; all strobes are 0.
  - When the divider is 0, go to SHIFT.
  - WAIT lasts RATE-1 cycles.
- SHIFT (1 cycle):
  - reg_shift_en=1, reg_par_load=0, reg_rot_left=dir, reg_asr=arith.
  - steps_left decrements.
  - If steps_left was 1, go to DONE; otherwise reload the divider with RATE-2 and go to WAIT.
- Strobe spacing: the LOAD strobe to the first SHIFT strobe, and SHIFT to SHIFT, are exactly RATE cycles apart.
- DONE (1 cycle): done=1, then go to IDLE. A new handshake is possible on the cycle after DONE.
- reg_data, reg_rot_left and reg_asr hold their latched values while busy. They are 0 in IDLE.
- steps_left shows the latched cmd_steps from LOAD onward and reaches 0 at DONE.
- abort:
  - Effective in LOAD, WAIT and SHIFT: next state is IDLE, with no done pulse and no strobe in the following cycles.
  - If abort arrives in the same cycle as a SHIFT, that shift's strobes are still asserted.
  - Ignored in IDLE and DONE.
- Simultaneous reset and any other input: reset wins.
- Divider arithmetic is unsigned DIV_W. RATE values below 2 are a configuration error and are flagged by a simulation assertion.

Decomposition:
- Package rotate_seq_pkg holds:
  - the state enum (IDLE, LOAD, WAIT, SHIFT, DONE);
  - the RATE defaults;
  - a function mapping rate_sel to a divider reload value.
- One sub-module, rate_divider: a loadable down-counter with load value, enable and zero flag.
- The FSM and latches stay in rotate_sequencer.

Test Plan:
- Load 0x81, dir=0, steps=3, rate_sel=0 (RATE0=2):
  - Handshake at cycle 0; par_load at cycle 1; shift_en at cycles 3, 5 and 7; done at cycle 8.
  - A register model ends at 0x30.
- Load 0x90, dir=0, arith=1, steps=2, rate_sel=1 (RATE1=4):
  - reg_asr=1 on both shifts, spaced 4 cycles apart.
  - The model gives 0xC8, then 0xE4.
- Load 0x01, dir=1, arith=1, steps=15, rate_sel=0:
  - reg_asr stays 0 and reg_rot_left=1 on all 15 shifts.
  - steps_left counts 15 down to 0 and the model ends at 0x80.
- steps=0, load 0x5A:
  - A single par_load cycle, then done on the next cycle.
  - There are no shift strobes.
- Command issued, then abort in the second WAIT cycle:
  - busy drops the next cycle; no done pulse and no further strobes.
  - cmd_ready=1 and a new command is accepted immediately.
- reset asserted during SHIFT of a 10-step command:
  - The next cycle shows the reset state: outputs 0, cmd_ready=1, steps_left=0.
  - A cmd_valid held through reset is accepted on the first cycle after reset deasserts.
